dmem_arbiter: RTL

Two-port arbiter and sequencer for the 256x8 single-port data memory. Requesters issue read or write transactions over a valid/ready handshake. The block grants at most one memory access per cycle and drives the memory's address, write-enable and write-data pins. Read results return on a per-port response channel and are held there. It sits between the core's load/store stage (port 0) and the test/DMA loader (port 1) on one side and the data memory on the other.

---
 rtl/dmem_pkg.sv | 16 +
 rtl/rr_arb2.sv | 41 ++++
 rtl/dmem_arbiter.sv | 95 +++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory arbiter.
// Widths and arbitration modes used by core, loader and arbiter.
package dmem_pkg;

  localparam int DMEM_ADDR_W = 8;
  localparam int DMEM_DATA_W = 8;

  localparam bit ARB_RR    = 1'b1;
  localparam bit ARB_FIXED = 1'b0;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-request arbiter with a priority pointer.
// Round-robin or fixed (port 0 wins) selected by ARB_MODE.
module rr_arb2
  import dmem_pkg::*;
#(
  parameter bit ARB_MODE = ARB_RR
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  port_e prio_q, prio_d;
  logic  rr_pick1;

  assign rr_pick1 = (ARB_MODE == ARB_RR) && (prio_q == PORT1);

  always_comb begin
    gnt_o = 2'b00;
    unique case (1'b1)
      (req_i == 2'b11): gnt_o = rr_pick1 ? 2'b10 : 2'b01;
      (req_i == 2'b01): gnt_o = 2'b01;
      (req_i == 2'b10): gnt_o = 2'b10;
      default:          gnt_o = 2'b00;
    endcase
  end

  // Pointer moves to whichever port lost (or did not ask).
  always_comb begin
    prio_d = prio_q;
    if (gnt_o[0])      prio_d = PORT1;
    else if (gnt_o[1]) prio_d = PORT0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio_q <= PORT0;
    else        prio_q <= prio_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the 256x8 single-port data memory.
// Reads return one cycle after grant; last read data is held per port.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int DATA_W   = DMEM_DATA_W,
  parameter bit ARB_MODE = ARB_RR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_0,
  output logic              req_ready_0,
  input  logic              req_we_0,
  input  logic [ADDR_W-1:0] req_addr_0,
  input  logic [DATA_W-1:0] req_wdata_0,
  output logic              rsp_valid_0,
  output logic [DATA_W-1:0] rsp_data_0,
  input  logic              req_valid_1,
  output logic              req_ready_1,
  input  logic              req_we_1,
  input  logic [ADDR_W-1:0] req_addr_1,
  input  logic [DATA_W-1:0] req_wdata_1,
  output logic              rsp_valid_1,
  output logic [DATA_W-1:0] rsp_data_1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [1:0]        req, gnt;
  logic              any_gnt;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        pend_q, pend_d;
  logic [DATA_W-1:0] hold0_q, hold0_d;
  logic [DATA_W-1:0] hold1_q, hold1_d;

  // No grants while reset is held, so outputs sit at reset values.
  assign req = {req_valid_1, req_valid_0} & {2{rst_n}};

  rr_arb2 #(
    .ARB_MODE(ARB_MODE)
  ) u_arb (
    .clk  (clk),
    .rst_n(rst_n),
    .req_i(req),
    .gnt_o(gnt)
  );

  assign req_ready_0 = gnt[0];
  assign req_ready_1 = gnt[1];
  assign any_gnt     = |gnt;

  always_comb begin
    sel_we    = gnt[1] ? req_we_1    : req_we_0;
    sel_addr  = gnt[1] ? req_addr_1  : req_addr_0;
    sel_wdata = gnt[1] ? req_wdata_1 : req_wdata_0;
  end

  always_comb begin
    mem_we    = any_gnt & sel_we;
    mem_addr  = any_gnt ? sel_addr  : addr_q;
    mem_wdata = any_gnt ? sel_wdata : '0;
    addr_d    = mem_addr;
    pend_d    = gnt & {2{~sel_we}};
  end

  always_comb begin
    hold0_d     = pend_q[0] ? mem_rdata : hold0_q;
    hold1_d     = pend_q[1] ? mem_rdata : hold1_q;
    rsp_valid_0 = pend_q[0];
    rsp_valid_1 = pend_q[1];
    rsp_data_0  = hold0_d;
    rsp_data_1  = hold1_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      pend_q  <= '0;
      hold0_q <= '0;
      hold1_q <= '0;
    end else begin
      addr_q  <= addr_d;
      pend_q  <= pend_d;
      hold0_q <= hold0_d;
      hold1_q <= hold1_d;
    end
  end

endmodule
